uart_rx_deser: RTL and testbench

UART receive deserializer: oversamples the serial line `rxd` on a baud-rate tick, detects and validates start bits, shifts in 8 data bits LSB-first, checks the stop bit and presents each completed byte with a one-cycle ready strobe. It is the stage directly upstream of the receive controller's FIFO. `dout`/`rx_rdy` map onto the FIFO write data and write strobe; `frame_err` feeds the status logic. Format is fixed 8N1.

---
 rtl/uart_rx_deser.sv | 134 +++++++++++++
 tb/tb_uart_rx_deser.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive deserializer: oversampled start validation, LSB-first data
// shift, stop-bit check, one-cycle rx_rdy / frame_err strobes.
module uart_rx_deser #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bclk_tick,
    input  logic       en,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       rx_rdy,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(OVERSAMPLE - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    dout_q, dout_d;
    logic          rx_rdy_q, rx_rdy_d;
    logic          frame_err_q, frame_err_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          rxd_s;

    assign rxd_s = sync2_q;

    always_comb begin
        sync1_d     = rxd;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        dout_d      = dout_q;
        rx_rdy_d    = 1'b0;
        frame_err_d = 1'b0;

        // Losing enable mid-frame drops the partial byte without a strobe.
        if (state_q != IDLE && !en) begin
            state_d = IDLE;
        end else if (bclk_tick) begin
            case (state_q)
                IDLE: begin
                    if (en && !rxd_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_d   = '0;
                        bit_d   = 3'd0;
                        state_d = rxd_s ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        shift_d = {rxd_s, shift_q[7:1]};
                        if (bit_q == 3'd7) state_d = STOP;
                        else               bit_d   = bit_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit lets a back-to-back start edge be seen.
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (rxd_s) begin
                            dout_d   = shift_q;
                            rx_rdy_d = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (rxd_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            dout_q      <= 8'h00;
            rx_rdy_q    <= 1'b0;
            frame_err_q <= 1'b0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            rx_rdy_q    <= rx_rdy_d;
            frame_err_q <= frame_err_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
        end
    end

    assign dout      = dout_q;
    assign rx_rdy    = rx_rdy_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: table of whole frames plus hand-written
// glitch, break, abort and mid-frame reset sequences.
module tb_uart_rx_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       bclk_tick = 1'b0;
    logic       en;
    logic       rxd;
    logic [7:0] dout;
    logic       rx_rdy;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_deser #(.OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bclk_tick (bclk_tick),
        .en        (en),
        .rxd       (rxd),
        .dout      (dout),
        .rx_rdy    (rx_rdy),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One tick every 4th clk.
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            bclk_tick = (div == 0);
        end
    end

    int tick_num = 0;
    always @(posedge clk) if (bclk_tick) tick_num++;

    // Output monitor, sampled on the falling edge.
    int rdy_cnt = 0, ferr_cnt = 0, rise_cnt = 0, busy_clks = 0, viol = 0;
    int t_start = 0, t_rdy = 0;
    logic prev_rdy = 1'b0, prev_ferr = 1'b0, prev_busy = 1'b0;
    always @(negedge clk) begin
        if (rx_rdy && frame_err) viol++;
        if (rx_rdy && prev_rdy) viol++;
        if (frame_err && prev_ferr) viol++;
        if (rx_rdy) begin rdy_cnt++; t_rdy = tick_num; end
        if (frame_err) ferr_cnt++;
        if (busy && !prev_busy) begin rise_cnt++; t_start = tick_num; end
        if (busy) busy_clks++;
        prev_rdy  = rx_rdy;
        prev_ferr = frame_err;
        prev_busy = busy;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        rxd = v;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         idle_bits;
        int         exp_rdy;
        int         exp_ferr;
        logic [7:0] exp_dout;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int r0, f0, s0, lat;
        vecs[0] = '{8'hA5, 1'b1, 2, 1, 0, 8'hA5, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 0, 1, 0, 8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 2, 1, 0, 8'hFF, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 2, 0, 1, 8'hFF, 1'b1};
        vecs[4] = '{8'hC3, 1'b1, 1, 1, 0, 8'hC3, 1'b0};

        rst = 1'b1; en = 1'b1; rxd = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_dout", dout, 8'h00);
        check("reset_rdy", rx_rdy, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        repeat (64) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            r0 = rdy_cnt; f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop);
            check($sformatf("v%0d_rdy", i), rdy_cnt - r0, vecs[i].exp_rdy);
            check($sformatf("v%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("v%0d_dout", i), dout, vecs[i].exp_dout);
            check($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
            if (vecs[i].exp_rdy != 0) begin
                lat = t_rdy - t_start;
                check($sformatf("v%0d_latency_ok", i), int'(lat >= 151 && lat <= 153), 1);
            end
            repeat (vecs[i].idle_bits) bit_time(1'b1);
        end

        // Glitch: low for 4 ticks only.
        r0 = rdy_cnt; f0 = ferr_cnt; s0 = busy_clks;
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        rxd = 1'b1;
        repeat (128) @(negedge clk);
        check("glitch_rdy", rdy_cnt - r0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_busy_clks", busy_clks - s0, 32);
        check("glitch_busy_end", busy, 0);

        // Break: good A5, then 3C with low stop held for 20 more bit times, then 5A.
        send_frame(8'hA5, 1'b1);
        bit_time(1'b1);
        check("brk_pre_dout", dout, 8'hA5);
        r0 = rdy_cnt; f0 = ferr_cnt; s0 = rise_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (20) bit_time(1'b0);
        check("brk_ferr", ferr_cnt - f0, 1);
        check("brk_rdy", rdy_cnt - r0, 0);
        check("brk_no_restart", rise_cnt - s0, 1);
        check("brk_busy_low_line", busy, 1);
        check("brk_dout_held", dout, 8'hA5);
        bit_time(1'b1);
        check("brk_busy_released", busy, 0);
        r0 = rdy_cnt;
        send_frame(8'h5A, 1'b1);
        bit_time(1'b1);
        check("brk_next_rdy", rdy_cnt - r0, 1);
        check("brk_next_dout", dout, 8'h5A);

        // Abort: drop en mid data bit 3 of 0x81.
        r0 = rdy_cnt; f0 = ferr_cnt;
        bit_time(1'b0);
        bit_time(1'b1); bit_time(1'b0); bit_time(1'b0);
        rxd = 1'b0;
        repeat (32) @(negedge clk);
        check("abort_busy_before", busy, 1);
        en = 1'b0;
        @(negedge clk);
        check("abort_busy_next_clk", busy, 0);
        repeat (32) @(negedge clk);
        rxd = 1'b1;
        repeat (4) bit_time(1'b1);
        check("abort_no_rdy", rdy_cnt - r0, 0);
        check("abort_no_ferr", ferr_cnt - f0, 0);
        check("abort_dout_held", dout, 8'h5A);
        en = 1'b1;
        bit_time(1'b1);
        send_frame(8'h81, 1'b1);
        bit_time(1'b1);
        check("abort_retry_rdy", rdy_cnt - r0, 1);
        check("abort_retry_dout", dout, 8'h81);

        // Reset during data bit 5 of 0x7E.
        r0 = rdy_cnt;
        bit_time(1'b0);
        for (int i = 0; i < 5; i++) bit_time(i[0] ? 1'b1 : 1'b0 ^ (i != 0));
        rxd = 1'b1;
        repeat (32) @(negedge clk);
        check("rst_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_dout", dout, 8'h00);
        check("rst_async_busy", busy, 0);
        check("rst_async_rdy", rx_rdy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) bit_time(1'b1);
        check("rst_no_strobe", rdy_cnt - r0, 0);
        send_frame(8'h7E, 1'b1);
        bit_time(1'b1);
        check("rst_after_rdy", rdy_cnt - r0, 1);
        check("rst_after_dout", dout, 8'h7E);

        check("pulse_rules", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
